wb_master_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter that lets the MiniMIPS32 instruction-side and data-side `wishbone_bus_if` masters share a single external Wishbone slave port. It sits between the CPU core's two master interfaces and the system bus. It grants the slave to one master at a time and holds the grant for the master's whole `cyc` cycle. A per-access watchdog converts a hung slave into an error termination, so the pipeline stall always ends.

---
 rtl/wb_master_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_master_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with fixed or round-robin tie-break
// and a per-access watchdog that turns a hung slave into an error termination.
module wb_master_arbiter #(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state, state_nxt;
    logic          last_grant, last_grant_nxt;
    logic [CW-1:0] wd_cnt, wd_cnt_nxt;
    logic [1:0]    grant_q;
    logic          m0_req, m1_req, sel_stb, fire;

    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;

    // last_grant: 0 = m0 served last, 1 = m1 served last
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    state_nxt = (PRIORITY_MODE == 1 && !last_grant) ? GNT1 : GNT0;
                else if (m0_req)
                    state_nxt = GNT0;
                else if (m1_req)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_grant_nxt = 1'b0;
                    state_nxt      = m1_req ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_grant_nxt = 1'b1;
                    state_nxt      = m0_req ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An ack in the same cycle as the limit wins, so fire requires no ack
    always_comb begin
        sel_stb = 1'b0;
        if (state == GNT0)
            sel_stb = m0_stb_i;
        else if (state == GNT1)
            sel_stb = m1_stb_i;
        fire = (TIMEOUT_CYCLES != 0) && sel_stb && !s_ack_i && (wd_cnt == T_LIM);
        if ((TIMEOUT_CYCLES == 0) || (state_nxt != state) || !sel_stb || s_ack_i || fire)
            wd_cnt_nxt = '0;
        else
            wd_cnt_nxt = wd_cnt + CW'(1);
    end

    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        timeout_o = fire;
        case (state)
            GNT0: begin
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_stb_o   = m0_stb_i & ~fire;
                s_cyc_o   = m0_cyc_i & ~fire;
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i & m0_stb_i & ~fire;
                m0_err_o  = fire;
            end
            GNT1: begin
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_stb_o   = m1_stb_i & ~fire;
                s_cyc_o   = m1_cyc_i & ~fire;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i & m1_stb_i & ~fire;
                m1_err_o  = fire;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

    // Reset leaves last_grant on m1 so the first round-robin tie goes to m0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            grant_q    <= 2'b00;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wd_cnt     <= wd_cnt_nxt;
            grant_q    <= {state_nxt == GNT1, state_nxt == GNT0};
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: a fixed-priority and a round-robin instance share
// one stimulus; acked reads are checked against a scoreboard queue per instance.
module tb_wb_master_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
    logic [3:0]  m0_sel, m1_sel;

    logic [31:0] f_m0_data, f_m1_data, f_s_addr, f_s_data;
    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_s_we, f_s_stb, f_s_cyc, f_timeout;
    logic [3:0]  f_s_sel;
    logic [1:0]  f_grant;

    logic [31:0] r_m0_data, r_m1_data, r_s_addr, r_s_data;
    logic        r_m0_ack, r_m0_err, r_m1_ack, r_m1_err, r_s_we, r_s_stb, r_s_cyc, r_timeout;
    logic [3:0]  r_s_sel;
    logic [1:0]  r_grant;

    int total = 0;
    int bad   = 0;

    logic [32:0] q_f[$];
    logic [32:0] q_r[$];
    logic [32:0] e_f, e_r;

    wb_master_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut_fix (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_data_o(f_m0_data), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_data_o(f_m1_data), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
        .s_addr_o(f_s_addr), .s_data_o(f_s_data), .s_we_o(f_s_we), .s_sel_o(f_s_sel),
        .s_stb_o(f_s_stb), .s_cyc_o(f_s_cyc), .s_data_i(s_rdata), .s_ack_i(s_ack),
        .grant_o(f_grant), .timeout_o(f_timeout)
    );

    wb_master_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_data_o(r_m0_data), .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_data_o(r_m1_data), .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err),
        .s_addr_o(r_s_addr), .s_data_o(r_s_data), .s_we_o(r_s_we), .s_sel_o(r_s_sel),
        .s_stb_o(r_s_stb), .s_cyc_o(r_s_cyc), .s_data_i(s_rdata), .s_ack_i(s_ack),
        .grant_o(r_grant), .timeout_o(r_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic cyc, input logic stb,
                                 input logic [31:0] addr, input logic we);
        if (k == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_addr = addr; m0_we = we;
            m0_wdata = addr ^ 32'hA5A5_0000; m0_sel = 4'hF;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_addr = addr; m1_we = we;
            m1_wdata = addr ^ 32'hA5A5_0000; m1_sel = 4'hF;
        end
    endtask

    task automatic slaveResp(input logic ack, input logic who, input logic [31:0] d);
        s_ack   = ack;
        s_rdata = ack ? d : 32'h0;
        if (ack) begin
            q_f.push_back({who, d});
            q_r.push_back({who, d});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (f_m0_ack || f_m1_ack) begin
            if (q_f.size() == 0)
                checkOutput("sb_fix_extra_ack", 32'd1, 32'd0);
            else begin
                e_f = q_f.pop_front();
                checkOutput("sb_fix_who", {31'b0, f_m1_ack}, {31'b0, e_f[32]});
                checkOutput("sb_fix_data", f_m1_ack ? f_m1_data : f_m0_data, e_f[31:0]);
            end
        end
        if (r_m0_ack || r_m1_ack) begin
            if (q_r.size() == 0)
                checkOutput("sb_rr_extra_ack", 32'd1, 32'd0);
            else begin
                e_r = q_r.pop_front();
                checkOutput("sb_rr_who", {31'b0, r_m1_ack}, {31'b0, e_r[32]});
                checkOutput("sb_rr_data", r_m1_ack ? r_m1_data : r_m0_data, e_r[31:0]);
            end
        end
    end

    initial begin
        int exp_k;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0);
        s_ack = 1'b0; s_rdata = 32'h0;

        @(negedge clk);
        checkOutput("rst_grant_fix", f_grant, 2'b00);
        checkOutput("rst_grant_rr", r_grant, 2'b00);
        checkOutput("rst_s_cyc", f_s_cyc, 0);
        checkOutput("rst_s_stb", r_s_stb, 0);
        checkOutput("rst_timeout", f_timeout, 0);
        step(); step();
        rst = 1'b1;

        applyStimulus(1, 1, 1, 32'h0000_0100, 0);
        @(negedge clk);
        checkOutput("single_idle_stb", f_s_stb, 0);
        step(); @(negedge clk);
        checkOutput("single_grant_fix", f_grant, 2'b10);
        checkOutput("single_grant_rr", r_grant, 2'b10);
        checkOutput("single_s_addr", f_s_addr, 32'h0000_0100);
        checkOutput("single_s_stb", f_s_stb, 1);
        step(); @(negedge clk);
        checkOutput("single_wait_ack", f_m1_ack, 0);
        step(); slaveResp(1, 1, 32'hCAFE_0100); @(negedge clk);
        checkOutput("single_m1_ack", f_m1_ack, 1);
        checkOutput("single_m0_ack", f_m0_ack, 0);
        checkOutput("single_m0_data", f_m0_data, 32'h0);
        step(); slaveResp(0, 0, 0); applyStimulus(1, 0, 0, 32'h0, 0); @(negedge clk);
        checkOutput("single_release_grant", f_grant, 2'b10);
        step(); @(negedge clk);
        checkOutput("single_idle_after", f_grant, 2'b00);

        step(); applyStimulus(0, 1, 1, 32'h200, 0); applyStimulus(1, 1, 1, 32'h300, 0);
        @(negedge clk);
        step(); slaveResp(1, 0, 32'h1111_0200); @(negedge clk);
        checkOutput("tie_fix_first", f_grant, 2'b01);
        checkOutput("tie_rr_first", r_grant, 2'b01);
        checkOutput("tie_s_addr", f_s_addr, 32'h200);
        step(); slaveResp(0, 0, 0); applyStimulus(0, 0, 0, 32'h0, 0); @(negedge clk);
        checkOutput("tie_release", f_grant, 2'b01);
        step(); slaveResp(1, 1, 32'h2222_0300); @(negedge clk);
        checkOutput("handoff_fix", f_grant, 2'b10);
        checkOutput("handoff_rr", r_grant, 2'b10);
        checkOutput("handoff_s_addr", f_s_addr, 32'h300);
        checkOutput("handoff_s_stb", f_s_stb, 1);
        step(); slaveResp(0, 0, 0); applyStimulus(1, 0, 0, 32'h0, 0); @(negedge clk);
        step(); @(negedge clk);
        checkOutput("tie_idle", f_grant, 2'b00);

        step(); applyStimulus(0, 1, 1, 32'h600, 0); applyStimulus(1, 1, 1, 32'h700, 0);
        @(negedge clk);
        exp_k = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i > 0) applyStimulus(1 - exp_k, 1, 1, 32'h600 + 32'((1 - exp_k) * 256), 0);
            slaveResp(1, exp_k[0], 32'h1000 + 32'(i));
            @(negedge clk);
            checkOutput("rr_seq_rr", r_grant, exp_k == 1 ? 2'b10 : 2'b01);
            checkOutput("rr_seq_fix", f_grant, exp_k == 1 ? 2'b10 : 2'b01);
            step(); slaveResp(0, 0, 0); applyStimulus(exp_k, 0, 0, 32'h0, 0);
            @(negedge clk);
            exp_k = 1 - exp_k;
        end
        step(); applyStimulus(0, 0, 0, 32'h0, 0); @(negedge clk);
        checkOutput("rr_tail_grant", r_grant, 2'b01);
        step(); @(negedge clk);
        checkOutput("rr_idle", r_grant, 2'b00);

        step(); applyStimulus(0, 1, 1, 32'h610, 0); applyStimulus(1, 1, 1, 32'h710, 0);
        @(negedge clk);
        step(); @(negedge clk);
        checkOutput("tie2_fix_m0", f_grant, 2'b01);
        checkOutput("tie2_rr_m1", r_grant, 2'b10);
        step(); applyStimulus(0, 0, 0, 32'h0, 0); applyStimulus(1, 0, 0, 32'h0, 0);
        @(negedge clk);
        step(); @(negedge clk);
        checkOutput("tie2_idle_rr", r_grant, 2'b00);

        step(); applyStimulus(1, 1, 1, 32'h400, 0); @(negedge clk);
        step(); applyStimulus(0, 1, 1, 32'h800, 1); slaveResp(1, 1, 32'h0000_00B0);
        @(negedge clk);
        checkOutput("lock_grant_fix", f_grant, 2'b10);
        checkOutput("lock_m0_ack", f_m0_ack, 0);
        for (int b = 1; b < 3; b++) begin
            step(); slaveResp(1, 1, 32'h0000_00B0 + 32'(b)); @(negedge clk);
            checkOutput("lock_beat_grant_fix", f_grant, 2'b10);
            checkOutput("lock_beat_grant_rr", r_grant, 2'b10);
            checkOutput("lock_beat_m0_ack", r_m0_ack, 0);
        end
        step(); slaveResp(0, 0, 0); applyStimulus(1, 0, 0, 32'h0, 0); @(negedge clk);
        checkOutput("lock_release", f_grant, 2'b10);
        checkOutput("lock_release_m0_ack", f_m0_ack, 0);
        step(); slaveResp(1, 0, 32'h0000_D0D0); @(negedge clk);
        checkOutput("lock_m0_grant_fix", f_grant, 2'b01);
        checkOutput("lock_m0_grant_rr", r_grant, 2'b01);
        checkOutput("lock_s_we", f_s_we, 1);
        checkOutput("lock_s_data", f_s_data, 32'h800 ^ 32'hA5A5_0000);
        step(); slaveResp(0, 0, 0); applyStimulus(0, 0, 0, 32'h0, 0); @(negedge clk);
        step(); @(negedge clk);

        step(); applyStimulus(0, 1, 1, 32'h500, 1); @(negedge clk);
        for (int g = 0; g < 6; g++) begin
            step(); @(negedge clk);
            checkOutput("wd_err", f_m0_err, g == 4 ? 1 : 0);
            checkOutput("wd_timeout_fix", f_timeout, g == 4 ? 1 : 0);
            checkOutput("wd_timeout_rr", r_timeout, g == 4 ? 1 : 0);
            checkOutput("wd_s_stb", f_s_stb, g == 4 ? 0 : 1);
            checkOutput("wd_s_cyc", f_s_cyc, g == 4 ? 0 : 1);
            checkOutput("wd_grant", f_grant, 2'b01);
        end
        step(); applyStimulus(0, 0, 0, 32'h0, 0); @(negedge clk);
        step(); @(negedge clk);
        checkOutput("wd_idle", f_grant, 2'b00);

        step(); applyStimulus(0, 1, 1, 32'h504, 0); @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            step();
            if (g == 4) slaveResp(1, 0, 32'h5A5A_0504);
            @(negedge clk);
            checkOutput("late_err", f_m0_err, 0);
            checkOutput("late_timeout", r_timeout, 0);
            if (g == 4) begin
                checkOutput("late_ack", f_m0_ack, 1);
                checkOutput("late_s_stb", f_s_stb, 1);
            end
        end
        step(); slaveResp(0, 0, 0); applyStimulus(0, 0, 0, 32'h0, 0); @(negedge clk);
        step(); @(negedge clk);

        step(); applyStimulus(1, 1, 1, 32'h900, 0); @(negedge clk);
        step(); @(negedge clk);
        checkOutput("mid_s_cyc_before", f_s_cyc, 1);
        #2;
        rst = 1'b0;
        s_ack = 1'b1;
        #1;
        checkOutput("mid_rst_grant_fix", f_grant, 2'b00);
        checkOutput("mid_rst_grant_rr", r_grant, 2'b00);
        checkOutput("mid_rst_s_cyc", f_s_cyc, 0);
        checkOutput("mid_rst_s_stb", r_s_stb, 0);
        checkOutput("mid_rst_s_addr", f_s_addr, 32'h0);
        checkOutput("mid_rst_m1_ack", f_m1_ack, 0);
        checkOutput("mid_rst_m1_data", r_m1_data, 32'h0);
        s_ack = 1'b0;
        applyStimulus(1, 0, 0, 32'h0, 0);
        step(); step();
        rst = 1'b1;
        applyStimulus(0, 1, 1, 32'hA00, 0); applyStimulus(1, 1, 1, 32'hB00, 0);
        @(negedge clk);
        step(); @(negedge clk);
        checkOutput("post_rst_rr_tie", r_grant, 2'b01);
        checkOutput("post_rst_fix_tie", f_grant, 2'b01);
        step(); applyStimulus(0, 0, 0, 32'h0, 0); applyStimulus(1, 0, 0, 32'h0, 0);
        step(); step(); @(negedge clk);

        checkOutput("sb_fix_empty", q_f.size(), 0);
        checkOutput("sb_rr_empty", q_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
